mdu: RTL
========

# mdu

Parametrised multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy indication that the hazard unit uses to stall MFHI/MFLO/MTHI/MTLO and further MD instructions. It also executes MTHI/MTLO as single-cycle writes. HI/LO are read combinationally for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal: 1 or more)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal: 1 or more)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- md_op  in  3  operation in E stage: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is treated as NONE
- md_a  in  WIDTH  rs operand (forwarded)
- md_b  in  WIDTH  rt operand (forwarded)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  registered; an MD operation is in flight
- md_stall  out  1  busy OR (md_op is 1..4), combinational, for the hazard unit

## Operation
- Reset: hi=0, lo=0, busy=0, cycle counter=0, pending result registers=0.
- **IDLE** (busy=0):
  - md_op in 1..4: the operands are latched and the result is computed into pending_hi/pending_lo.
    - MULT: signed 2·WIDTH product; HI=upper half, LO=lower half.
    - MULTU: same as MULT, unsigned.
    - DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
    - DIVU: unsigned quotient and remainder.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES, and the unit moves to BUSY.
  - MTHI: hi←md_a at the edge; lo unchanged; busy stays 0.
  - MTLO: lo←md_a at the edge; hi unchanged; busy stays 0.
- **BUSY** (busy=1):
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1, hi/lo are loaded from pending, busy→0, and the unit returns to IDLE.
  - md_op is ignored while BUSY, including MTHI/MTLO. The hazard unit guarantees no MD instruction is issued; the unit does not rely on that.
- Division by zero (DIV/DIVU with md_b=0): timing is normal (DIV_CYCLES busy), but hi/lo are left unchanged at completion.
- Signed overflow (DIV with md_a=most-negative value, md_b=−1): LO=most-negative value (wraps), HI=0. No exception is raised.
- HI/LO are never partially updated; both change on the same edge, except for MTHI/MTLO.

## Timing
- md_op=MULT sampled at edge k: busy=1 from after edge k through the cycle before edge k+MULT_CYCLES.
- At edge k+MULT_CYCLES, hi/lo take the new result and busy=0 in the same cycle.
- DIV/DIVU follow the same timing with DIV_CYCLES.
- md_stall is high in the issue cycle (before edge k) and throughout busy. An MFHI stalled behind the operation reads the new value in the first cycle busy=0.
- A new MD op may be sampled at the completion edge + 1, i.e. back-to-back with one idle-visible cycle where md_stall reflects only the new op.
- Reset asserted mid-operation: at once, busy=0, hi=lo=0, and the pending result is discarded. After release the unit is IDLE.
- MTHI/MTLO: zero latency beyond the write edge. The new value is visible on hi/lo the next cycle.

## Structure
- Shared package mdu_pkg holds:
  - the md_op encoding constants (MD_NONE … MD_MTLO)
  - the operation-type width (3)
- The decoder in the control unit imports the same package.
- The arithmetic is behavioural (the `*` and `/` / `%` operators, with $signed casts on 2·WIDTH-extended operands), computed at issue. The counter models latency only.
- No sub-module is required; a single module with one always block for state and combinational result logic is sufficient.

## Test plan
- MULT: md_a=0xFFFFFFFE (−2), md_b=0x00000003 → after 5 busy cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high exactly 5 cycles.
- MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV: md_a=−7 (0xFFFFFFF9), md_b=2 → after 10 cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU: md_a=7, md_b=0, with hi=0x11, lo=0x22 beforehand → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI with md_a=0xDEADBEEF while idle → hi=0xDEADBEEF next cycle. The same MTHI issued while busy → ignored; hi keeps the MD result.
- Reset at busy cycle 3 of a DIV → busy=0, hi=lo=0 immediately; no later completion write occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared multiply/divide operation encoding, used by the MDU
//               and by the control-unit decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Width of the md_op field carried from decode into the E stage
  localparam int MD_OP_W = 3;

  // md_op encoding; the unused code 7 behaves as MD_NONE
  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  // True for the multi-cycle operations that raise busy
  function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multiply/divide unit owning HI/LO. MULT/MULTU/DIV/DIVU are
//               computed at issue into pending registers and committed after
//               a fixed latency; MTHI/MTLO write HI/LO directly when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   md_a,
  input  logic [WIDTH-1:0]   md_b,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               md_stall
);

  localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  // Architectural and in-flight state
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic               r_pend_wr;   // cleared for divide-by-zero: HI/LO keep old value
  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;

  // Operands widened to 2*WIDTH so products and the most-negative / -1
  // quotient are exact before truncation
  logic signed [2*WIDTH-1:0] w_sa;
  logic signed [2*WIDTH-1:0] w_sb;
  logic        [2*WIDTH-1:0] w_ua;
  logic        [2*WIDTH-1:0] w_ub;
  logic signed [2*WIDTH-1:0] w_sb_div;
  logic        [2*WIDTH-1:0] w_ub_div;
  logic signed [2*WIDTH-1:0] w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;
  logic                      w_b_zero;
  logic                      w_is_long;

  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_res_wr;
  logic [c_cnt_w-1:0] w_res_cnt;

  // Compute the full result of whatever long op is presented this cycle
  always_comb begin
    w_sa      = {{WIDTH{md_a[WIDTH-1]}}, md_a};
    w_sb      = {{WIDTH{md_b[WIDTH-1]}}, md_b};
    w_ua      = {{WIDTH{1'b0}}, md_a};
    w_ub      = {{WIDTH{1'b0}}, md_b};
    w_b_zero  = (md_b == '0);
    w_is_long = is_long_op(md_op);
    // A dummy divisor of 1 keeps the divider well-defined; the result is dropped
    w_sb_div  = w_b_zero ? {{(2*WIDTH-1){1'b0}}, 1'b1} : w_sb;
    w_ub_div  = w_b_zero ? {{(2*WIDTH-1){1'b0}}, 1'b1} : w_ub;
    w_sprod   = w_sa * w_sb;
    w_uprod   = w_ua * w_ub;

    w_res_hi  = '0;
    w_res_lo  = '0;
    w_res_wr  = 1'b0;
    w_res_cnt = '0;
    case (md_op)
      MD_MULT: begin
        w_res_hi  = w_sprod[2*WIDTH-1:WIDTH];
        w_res_lo  = w_sprod[WIDTH-1:0];
        w_res_wr  = 1'b1;
        w_res_cnt = c_cnt_w'(MULT_CYCLES);
      end
      MD_MULTU: begin
        w_res_hi  = w_uprod[2*WIDTH-1:WIDTH];
        w_res_lo  = w_uprod[WIDTH-1:0];
        w_res_wr  = 1'b1;
        w_res_cnt = c_cnt_w'(MULT_CYCLES);
      end
      MD_DIV: begin
        w_res_lo  = WIDTH'(w_sa / w_sb_div);
        w_res_hi  = WIDTH'(w_sa % w_sb_div);
        w_res_wr  = !w_b_zero;
        w_res_cnt = c_cnt_w'(DIV_CYCLES);
      end
      MD_DIVU: begin
        w_res_lo  = WIDTH'(w_ua / w_ub_div);
        w_res_hi  = WIDTH'(w_ua % w_ub_div);
        w_res_wr  = !w_b_zero;
        w_res_cnt = c_cnt_w'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Issue, latency countdown, commit, and direct HI/LO moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else if (r_busy) begin
      if (r_cnt == c_cnt_w'(1)) begin
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (w_is_long) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_wr <= w_res_wr;
      r_cnt     <= w_res_cnt;
      r_busy    <= 1'b1;
    end else if (md_op == MD_MTHI) begin
      r_hi <= md_a;
    end else if (md_op == MD_MTLO) begin
      r_lo <= md_a;
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign md_stall = r_busy | w_is_long;

endmodule
`default_nettype wire
